// File: rtl/fifo_pkg.sv
// fifo_pkg: shared lane-width, tag-width and pad helpers for the FIFO packer (tag enabled by FIFO_PACK_TAG_EN)
package fifo_pkg;
  localparam logic PAD_BIT = 1'b0;
  function automatic int lane_w(input int ratio);
    return $clog2(ratio);
  endfunction
  function automatic int tag_w(input int ratio);
`ifdef FIFO_PACK_TAG_EN
    return lane_w(ratio) + 1;
`else
    return 0 * ratio;
`endif
  endfunction
endpackage

// File: rtl/fifo_pack_lane_buf.sv
// fifo_pack_lane_buf: lane buffer, lane counter and emit-word assembly (lanes above the fill point stay at pad)
module fifo_pack_lane_buf
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int PACK_RATIO = 4,
  localparam int LANE_W    = lane_w(PACK_RATIO),
  localparam int DW        = IN_WIDTH * PACK_RATIO
) (
  input  logic                wr_clk,
  input  logic                rstn,
  input  logic                acc_i,
  input  logic                emit_i,
  input  logic [IN_WIDTH-1:0] data_i,
  output logic [LANE_W-1:0]   lane_o,
  output logic [DW-1:0]       word_o,
  output logic [LANE_W-1:0]   cnt_m1_o
);
  logic [DW-1:0]     pack_q, pack_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  always_comb begin
    word_o = pack_q;
    if (acc_i) word_o[lane_q*IN_WIDTH +: IN_WIDTH] = data_i;
    pack_d   = emit_i ? {DW{PAD_BIT}} : word_o;
    lane_d   = emit_i ? '0 : lane_q + LANE_W'(acc_i);
    cnt_m1_o = acc_i ? lane_q : lane_q - 1'b1;
    lane_o   = lane_q;
  end
  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      pack_q <= '0;
      lane_q <= '0;
    end else begin
      pack_q <= pack_d;
      lane_q <= lane_d;
    end
  end
endmodule

// File: rtl/fifo_pack_writer.sv
// fifo_pack_writer: packs PACK_RATIO s_data beats into one FIFO word with s_last/flush partial emission (FIFO_PACK_TAG_EN adds last+count tag)
module fifo_pack_writer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int PACK_RATIO = 4,
  localparam int LANE_W    = lane_w(PACK_RATIO),
  localparam int DW        = IN_WIDTH * PACK_RATIO,
  localparam int OUT_WIDTH = DW + tag_w(PACK_RATIO)
) (
  input  logic                 wr_clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  input  logic                 flush,
  output logic                 fifo_wr_en,
  output logic [OUT_WIDTH-1:0] fifo_wr_data,
  input  logic                 fifo_wr_full,
  output logic [31:0]          words_written,
  output logic                 busy
);
  logic                 slot_free, acc, fl, emit_acc, emit, lane_nz;
  logic                 out_vld_q, out_vld_d, flush_pend_q, flush_pend_d;
  logic [OUT_WIDTH-1:0] out_q, out_d, new_word;
  logic [LANE_W-1:0]    lane, cnt_m1;
  logic [DW-1:0]        word;
  logic [31:0]          words_q;
  fifo_pack_lane_buf #(.IN_WIDTH(IN_WIDTH), .PACK_RATIO(PACK_RATIO)) u_buf (
    .wr_clk(wr_clk), .rstn(rstn), .acc_i(acc), .emit_i(emit), .data_i(s_data),
    .lane_o(lane), .word_o(word), .cnt_m1_o(cnt_m1)
  );
  always_comb begin
    slot_free    = !out_vld_q || !fifo_wr_full;
    acc          = s_valid && slot_free;
    fl           = flush || flush_pend_q;
    lane_nz      = lane != '0;
    emit_acc     = acc && (lane == LANE_W'(PACK_RATIO - 1) || s_last || fl);
    emit         = emit_acc || (!acc && fl && lane_nz && slot_free);
    flush_pend_d = !acc && fl && lane_nz && !slot_free;
`ifdef FIFO_PACK_TAG_EN
    new_word     = {emit_acc && s_last, cnt_m1, word};
`else
    new_word     = word | OUT_WIDTH'(cnt_m1 & '0);
`endif
    out_vld_d    = emit || (out_vld_q && fifo_wr_full);
    out_d        = emit ? new_word : out_q;
  end
  assign s_ready       = slot_free;
  assign fifo_wr_en    = out_vld_q && !fifo_wr_full;
  assign fifo_wr_data  = out_q;
  assign words_written = words_q;
  assign busy          = lane_nz || out_vld_q || flush_pend_q;
  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      words_q      <= '0;
    end else begin
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      flush_pend_q <= flush_pend_d;
      if (fifo_wr_en) words_q <= words_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_fifo_pack_writer.sv
// tb_fifo_pack_writer: scoreboard bench for fifo_pack_writer (IN_WIDTH=8, PACK_RATIO=4)
module tb_fifo_pack_writer;
`ifdef FIFO_PACK_TAG_EN
  localparam int OW = 35;
`else
  localparam int OW = 32;
`endif
  logic          wr_clk = 1'b0;
  logic          rstn, s_valid, s_ready, s_last, flush, fifo_wr_en, fifo_wr_full, busy;
  logic [7:0]    s_data;
  logic [OW-1:0] fifo_wr_data;
  logic [31:0]   words_written;
  logic [OW-1:0] exp_q[$];
  logic [31:0]   mbuf;
  int            mcnt, n_tests, n_fail, nready, run, max_run;

  fifo_pack_writer #(.IN_WIDTH(8), .PACK_RATIO(4)) dut (
    .wr_clk(wr_clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .flush(flush), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .words_written(words_written), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] mk(input logic [31:0] d, input int c, input logic l);
    return OW'({l, 2'(c - 1), d});
  endfunction

  task automatic model_add(input logic [7:0] d, input logic l);
    mbuf[mcnt*8 +: 8] = d;
    mcnt++;
    if (mcnt == 4 || l) begin
      exp_q.push_back(mk(mbuf, mcnt, l));
      mbuf = '0;
      mcnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge wr_clk);
      done = s_ready;
      @(posedge wr_clk);
      #1;
    end
    if (done) model_add(d, l);
    else check("accept_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge wr_clk);
    #1;
    flush = 1'b0;
    if (mcnt != 0) exp_q.push_back(mk(mbuf, mcnt, 1'b0));
    mbuf = '0;
    mcnt = 0;
  endtask

  always @(negedge wr_clk) begin
    if (rstn) begin
      check("wr_en_while_full", 64'(fifo_wr_en & fifo_wr_full), 64'd0);
      if (!s_ready && !fifo_wr_full) nready++;
      run = fifo_wr_en ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) check("unexpected_write", 64'(fifo_wr_data), 64'd0 - 64'd1);
        else check("wr_data", 64'(fifo_wr_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; flush = 1'b0; fifo_wr_full = 1'b0;
    mbuf = '0; mcnt = 0; n_tests = 0; n_fail = 0; nready = 0; run = 0; max_run = 0;
    #12;
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    @(posedge wr_clk);
    #1 rstn = 1'b1;
    idle(1);
    // continuous stream, two full words
    nready = 0;
    for (int i = 1; i <= 8; i++) beat(8'(8'h11 * i), 1'b0);
    idle(3);
    check("t1_words", 64'(words_written), 64'd2);
    check("t1_ready_low", 64'(nready), 64'd0);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);
    // short frame closed by s_last
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b0);
    beat(8'hA3, 1'b1);
    idle(3);
    check("t2_words", 64'(words_written), 64'd3);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);
    // hold while full, next word stalls until full drops
    fifo_wr_full = 1'b1;
    for (int i = 0; i < 4; i++) beat(8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      check("t3_hold_ready", 64'(s_ready), 64'd0);
      check("t3_hold_busy", 64'(busy), 64'd1);
    end
    @(posedge wr_clk);
    #1;
    fork
      for (int i = 0; i < 4; i++) beat(8'(8'hC0 + i), 1'b0);
      begin
        idle(2);
        fifo_wr_full = 1'b0;
      end
    join
    idle(3);
    check("t3_words", 64'(words_written), 64'd5);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);
    // flush of a partial word while full, then flush with nothing pending
    beat(8'h5A, 1'b0);
    fifo_wr_full = 1'b1;
    do_flush();
    idle(3);
    check("t4_busy_held", 64'(busy), 64'd1);
    check("t4_words_held", 64'(words_written), 64'd5);
    fifo_wr_full = 1'b0;
    idle(2);
    check("t4_words", 64'(words_written), 64'd6);
    do_flush();
    idle(3);
    check("t4_empty_flush", 64'(words_written), 64'd6);
    check("t4_idle_busy", 64'(busy), 64'd0);
    // asynchronous reset mid-frame
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("t5_wr_en", 64'(fifo_wr_en), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_words", 64'(words_written), 64'd0);
    mbuf = '0;
    mcnt = 0;
    @(posedge wr_clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 4; i++) beat(8'(8'hD0 + i), 1'b0);
    idle(3);
    check("t5_words_after", 64'(words_written), 64'd1);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);
    // back-to-back single-beat frames and counter wrap
    force dut.words_q = 32'hFFFF_FFFE;
    idle(1);
    release dut.words_q;
    max_run = 0;
    beat(8'hE1, 1'b1);
    beat(8'hE2, 1'b1);
    beat(8'hE3, 1'b1);
    idle(3);
    check("t6_back_to_back", 64'(max_run), 64'd3);
    check("t6_wrap", 64'(words_written), 64'd1);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
